// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - multi-cycle shift-and-add integer multiplier
//
// Computes a WIDTH x WIDTH multiply, signed or unsigned, one partial product per clock.
// Signed operands are converted to their magnitudes when the operation is accepted.
// The sign is applied to the 2*WIDTH-bit result when it is written to product.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      request a multiply; accepted in IDLE or DONE
//   signed_op  1 = two's-complement operands, 0 = unsigned; sampled with start
//   a, b       multiplicand / multiplier; sampled with start
//   busy       high while iterating (RUN)
//   done       one-cycle pulse when product is valid
//   product    2*WIDTH-bit result; holds until the next done or reset

module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   mplier_shift;
  logic [2*WIDTH-1:0] prod_raw;
  logic               last;
  logic               accept;

  // One iteration step.
  // The add is WIDTH+1 bits wide, so its carry becomes the MSB after the right shift.
  // The low bit shifted out of the accumulator fills the vacated top of the multiplier.
  always_comb begin
    sum          = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_shift    = sum[WIDTH:1];
    mplier_shift = {sum[0], mplier[WIDTH-1:1]};
    prod_raw     = {acc_shift, mplier_shift};
  end

  assign last   = (cnt == CNT_W'(WIDTH-1));
  assign accept = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      // The magnitude of the most negative value equals the value itself when read as unsigned.
      mcand  <= (signed_op && a[WIDTH-1]) ? -a : a;
      mplier <= (signed_op && b[WIDTH-1]) ? -b : b;
      neg    <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_shift;
      mplier <= mplier_shift;
      cnt    <= cnt + CNT_W'(1);
      // The final iteration and the result write-back share the DONE entry edge.
      if (last) begin
        product <= neg ? (~prod_raw) + {{(2*WIDTH-1){1'b0}}, 1'b1} : prod_raw;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized self-checking bench for shift_add_multiplier

module tb_shift_add_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Called at a negedge with the DUT idle.
  // Operand inputs are scrambled once the operation is accepted.
  // pulse_at > 0 raises start with 9*9 for one cycle at that point in the run.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic s,
                        input int pulse_at, input string tag);
    logic [63:0] exp;
    int l;
    int busy_cnt;
    exp = ref_mul(oa, ob, s);
    a = oa;
    b = ob;
    signed_op = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    l = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        l = k;
        break;
      end
      if (busy) busy_cnt++;
      if (k == pulse_at) begin
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(l), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_done_single"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, 0, "t1");
    check("t1_const", product, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "t2");
    check("t2_const", product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, "t3a");
    check("t3a_const", product, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "t3b");
    check("t3b_const", product, 64'h4000_0000_0000_0000);
    run_op(32'd7, 32'd6, 1'b0, 5, "t4");
    check("t4_const", product, 64'd42);

    // Back-to-back: start held through DONE with the next operands waiting.
    a = 32'd2;
    b = 32'd2;
    signed_op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 32'd4;
    b = 32'd4;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("t5_lat1", 64'(lat), 64'(W + 1));
    check("t5_p1", product, 64'd4);
    @(negedge clk);
    check("t5_no_idle", {63'b0, busy}, 64'd1);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("t5_lat2", 64'(lat), 64'(W + 1));
    check("t5_p2", product, 64'd16);
    @(negedge clk);

    // Reset mid-run.
    a = 32'd100;
    b = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy", {63'b0, busy}, 64'd0);
    check("t6_done", {63'b0, done}, 64'd0);
    check("t6_product", product, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("t6_no_done", 64'(seen), 64'd0);

    // Reset and start at the same edge: reset wins.
    run_op(32'd11, 32'd13, 1'b0, 0, "pre_rs");
    a = 32'd5;
    b = 32'd5;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rs_busy", {63'b0, busy}, 64'd0);
    check("rs_product", product, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rs_no_op", 64'(seen), 64'd0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      int sel;
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) ra = 32'd0;
      if (sel == 1) ra = 32'h8000_0000;
      if (sel == 2) rb = 32'h8000_0000;
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 30), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
